ann_argmax_display: RTL and testbench

- Downstream stage of the ANN core: consumes the final-layer node outputs once the core signals done_processing.
- Performs a sequential argmax over NUM_CLASSES signed 16-bit node values, one compare per cycle.
- Registers the winning class index and its value, and drives the board seven-segment display with the recognised digit.
- Snapshots its inputs at start, so the ANN core may begin the next image while the scan runs.

---
 rtl/ann_pkg.sv | 21 ++
 rtl/seven_seg_decoder.sv | 19 +
 rtl/ann_argmax_display.sv | 110 +++++++++++
 tb/tb_ann_argmax_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and constants for the ANN output stage:
// FSM state encoding and seven-segment glyphs.
package ann_pkg;

    localparam int ANN_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Segment order {dp,g,f,e,d,c,b,a}, active-high
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seven_seg_decoder.sv
// Class index to seven-segment glyph; indices above 9 show 'E'.
// The decimal point flags a negative (low-confidence) winner.
module seven_seg_decoder
    import ann_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       neg,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_E;
        if (digit < 4'd10) begin
            seg = SEG_DIGIT[digit];
        end
        seg[7] = neg;
    end

endmodule

// File: rtl/ann_argmax_display.sv
// Sequential argmax over the final-layer node outputs, one compare
// per cycle, with the winning class shown on the seven-segment display.
module ann_argmax_display
    import ann_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = ANN_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] node_vals [NUM_CLASSES],
    output logic              busy,
    output logic              result_valid,
    output logic [3:0]        class_idx,
    output logic [DATA_W-1:0] max_val,
    output logic [7:0]        seven_seg
);

    localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

    state_t            state;
    state_t            next;
    logic [DATA_W-1:0] shadow [NUM_CLASSES];
    logic [3:0]        scan_idx;
    logic [3:0]        best_idx;
    logic [DATA_W-1:0] best_val;
    logic [7:0]        seg;
    logic              take;

    // Strict compare so ties keep the lower index
    assign take = $signed(shadow[scan_idx]) > $signed(best_val);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next = SCAN;
                end
            end
            SCAN: begin
                if (scan_idx == LAST) begin
                    next = DONE;
                end
            end
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                shadow[i] <= '0;
            end
            scan_idx     <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            max_val      <= '0;
            seven_seg    <= SEG_BLANK;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            shadow[i] <= node_vals[i];
                        end
                        best_idx <= '0;
                        best_val <= node_vals[0];
                        scan_idx <= 4'd1;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_idx <= scan_idx;
                        best_val <= shadow[scan_idx];
                    end
                    scan_idx <= scan_idx + 4'd1;
                end
                DONE: begin
                    class_idx    <= best_idx;
                    max_val      <= best_val;
                    seven_seg    <= seg;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    seven_seg_decoder u_dec (
        .digit (best_idx),
        .neg   (best_val[DATA_W-1]),
        .seg   (seg)
    );

endmodule

// File: tb/tb_ann_argmax_display.sv
// Directed bench for ann_argmax_display: vector table plus
// hand sequences for snapshot, back-to-back and mid-scan reset.
module tb_ann_argmax_display;

    localparam int N = 10;

    typedef struct packed {
        logic [N-1:0][15:0] vals;
        logic [3:0]         idx;
        logic [15:0]        val;
        logic [7:0]         seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] node_vals [N];
    logic        busy;
    logic        result_valid;
    logic [3:0]  class_idx;
    logic [15:0] max_val;
    logic [7:0]  seven_seg;

    int total = 0;
    int bad = 0;
    vec_t tbl [6];

    always #5 clk = ~clk;

    ann_argmax_display #(
        .NUM_CLASSES (N),
        .DATA_W      (16)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .node_vals    (node_vals),
        .busy         (busy),
        .result_valid (result_valid),
        .class_idx    (class_idx),
        .max_val      (max_val),
        .seven_seg    (seven_seg)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) begin
            node_vals[i] = v.vals[i];
        end
    endtask

    task automatic pulse(input vec_t v);
        load(v);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_res(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (result_valid) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic check_out(input string nm, input vec_t v);
        chk({nm, " idx"}, 32'(class_idx), 32'(v.idx));
        chk({nm, " val"}, 32'(max_val), 32'(v.val));
        chk({nm, " seg"}, 32'(seven_seg), 32'(v.seg));
    endtask

    task automatic check_reset(input string nm);
        chk({nm, " busy"}, 32'(busy), 32'd0);
        chk({nm, " rv"}, 32'(result_valid), 32'd0);
        chk({nm, " idx"}, 32'(class_idx), 32'd0);
        chk({nm, " val"}, 32'(max_val), 32'd0);
        chk({nm, " seg"}, 32'(seven_seg), 32'd0);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int c;
        pulse(v);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        wait_res(c);
        chk({nm, " lat"}, 32'(c), 32'd10);
        check_out(nm, v);
        tick();
        chk({nm, " one"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int c;
        int pulses;
        int first;

        tbl[0].vals = {16'd3, 16'd2, 16'd1, 16'd299, 16'd0,
                       16'd7, 16'd20, 16'd300, -16'sd5, 16'd100};
        tbl[0].idx = 4'd2;
        tbl[0].val = 16'd300;
        tbl[0].seg = 8'h5B;

        tbl[1].vals = {-16'sd40, -16'sd40, -16'sd12, -16'sd40, -16'sd40,
                       -16'sd12, -16'sd40, -16'sd40, -16'sd40, -16'sd40};
        tbl[1].idx = 4'd4;
        tbl[1].val = 16'hFFF4;
        tbl[1].seg = 8'hE6;

        tbl[2].vals = {10{16'd5}};
        tbl[2].idx = 4'd0;
        tbl[2].val = 16'd5;
        tbl[2].seg = 8'h3F;

        tbl[3].vals = {16'h7FFF, {9{16'd0}}};
        tbl[3].idx = 4'd9;
        tbl[3].val = 16'h7FFF;
        tbl[3].seg = 8'h6F;

        tbl[4].vals = {10{16'h8000}};
        tbl[4].idx = 4'd0;
        tbl[4].val = 16'h8000;
        tbl[4].seg = 8'hBF;

        tbl[5].vals = {16'd0, 16'd0, 16'd1, {7{16'd0}}};
        tbl[5].idx = 4'd7;
        tbl[5].val = 16'd1;
        tbl[5].seg = 8'h07;

        for (int i = 0; i < N; i++) node_vals[i] = '0;

        // Reset then idle
        tick();
        tick();
        check_reset("in_rst");
        n_rst = 1'b1;
        tick();
        check_reset("idle");

        for (int t = 0; t < 6; t++) begin
            run_vec($sformatf("vec%0d", t), tbl[t]);
        end

        // Snapshot: new data and a second start 3 cycles into the scan
        pulse(tbl[0]);
        tick();
        tick();
        tick();
        load(tbl[3]);
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        first = -1;
        for (int k = 5; k <= 18; k++) begin
            tick();
            if (result_valid) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        chk("snap lat", 32'(first), 32'd10);
        chk("snap pulses", 32'(pulses), 32'd1);
        check_out("snap", tbl[0]);

        // Back-to-back: start in the result_valid cycle
        pulse(tbl[1]);
        wait_res(c);
        chk("b2b lat1", 32'(c), 32'd10);
        check_out("b2b first", tbl[1]);
        load(tbl[3]);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy", 32'(busy), 32'd1);
        wait_res(c);
        chk("b2b lat2", 32'(c), 32'd10);
        check_out("b2b second", tbl[3]);
        tick();

        // Reset mid-scan
        pulse(tbl[0]);
        for (int k = 0; k < 5; k++) tick();
        chk("mid busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check_reset("mid_rst");
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (result_valid) pulses++;
        end
        chk("mid no rv", 32'(pulses), 32'd0);
        check_reset("mid_after");
        run_vec("post_rst", tbl[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
